// File: rtl/wb_regfile_dump.sv
// Architectural register file at the MEM/WB consumer end.
// Holds the memtoreg write mux, two bypassed ID read ports and a
// valid/ready dump engine that streams every register to the debug unit.

// One architectural register; the top instantiates one per non-zero index.
module wb_regfile_dump_cell #(
  parameter int NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [NBITS-1:0] i_d,
  output logic [NBITS-1:0] o_q
);

  logic [NBITS-1:0] r_q;

  // Register storage, cleared by the asynchronous reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)    r_q <= '0;
    else if (i_we) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

module wb_regfile_dump #(
  parameter int NBITS = 32,
  parameter int RBITS = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NBITS-1:0] WB_result,
  input  logic [NBITS-1:0] WB_data,
  input  logic [RBITS-1:0] WB_rd,
  input  logic             WB_memtoreg,
  input  logic             WB_regwrite,
  input  logic [RBITS-1:0] ID_rs,
  input  logic [RBITS-1:0] ID_rt,
  output logic [NBITS-1:0] ID_rs_data,
  output logic [NBITS-1:0] ID_rt_data,
  input  logic             i_dump_start,
  input  logic             i_dump_ready,
  output logic             o_dump_valid,
  output logic [RBITS-1:0] o_dump_addr,
  output logic [NBITS-1:0] o_dump_data,
  output logic             o_dump_busy,
  output logic             o_dump_done
);

  localparam int NREG = 2**RBITS;
  localparam logic [RBITS-1:0] LAST_IDX = RBITS'(NREG-1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  logic [NREG-1:0][NBITS-1:0] w_regs;
  logic [NBITS-1:0]           w_wdata;
  logic                       w_wen;
  logic [RBITS-1:0]           w_next_idx;
  logic [NBITS-1:0]           w_next_data;

  state_t           r_state;
  logic             r_valid;
  logic [RBITS-1:0] r_addr;
  logic [NBITS-1:0] r_data;
  logic             r_busy;
  logic             r_done;

  // Bypassed read: r0 is zero, a write in flight to the same index wins,
  // otherwise the stored value.
  function automatic logic [NBITS-1:0] f_read(
    input logic [RBITS-1:0]           a,
    input logic [NREG-1:0][NBITS-1:0] regs,
    input logic                       we,
    input logic [RBITS-1:0]           rd,
    input logic [NBITS-1:0]           wd
  );
    if (a == '0)            return '0;
    else if (we && rd == a) return wd;
    else                    return regs[a];
  endfunction

  assign w_wdata = WB_memtoreg ? WB_data : WB_result;
  assign w_wen   = WB_regwrite && (WB_rd != '0);

  // r0 is hardwired; there is no storage behind it.
  assign w_regs[0] = '0;

  genvar g;
  generate
    for (g = 1; g < NREG; g++) begin : g_reg
      wb_regfile_dump_cell #(.NBITS(NBITS)) u_cell (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_we  (w_wen && (WB_rd == RBITS'(g))),
        .i_d   (w_wdata),
        .o_q   (w_regs[g])
      );
    end
  endgenerate

  assign ID_rs_data = f_read(ID_rs, w_regs, WB_regwrite, WB_rd, w_wdata);
  assign ID_rt_data = f_read(ID_rt, w_regs, WB_regwrite, WB_rd, w_wdata);

  // Next dump word is sampled with the same bypass rule so a write landing
  // on the edge that loads it is not lost.
  assign w_next_idx  = r_addr + 1'b1;
  assign w_next_data = f_read(w_next_idx, w_regs, WB_regwrite, WB_rd, w_wdata);

  // Dump engine: registered outputs, no bubbles between accepted words,
  // the held word is a snapshot and ignores later writes to its register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_dump_start) begin
            r_state <= S_SEND;
            r_valid <= 1'b1;
            r_addr  <= '0;
            r_data  <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_SEND: begin
          if (r_valid && i_dump_ready) begin
            if (r_addr == LAST_IDX) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_addr <= w_next_idx;
              r_data <= w_next_data;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_dump_valid = r_valid;
  assign o_dump_addr  = r_addr;
  assign o_dump_data  = r_data;
  assign o_dump_busy  = r_busy;
  assign o_dump_done  = r_done;

endmodule

// File: tb/tb_wb_regfile_dump.sv
// Bench for wb_regfile_dump: vector table for the write mux / read ports,
// then dump sequences checked against a queue of expected words.
module tb_wb_regfile_dump;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] WB_result, WB_data;
  logic [4:0]  WB_rd;
  logic        WB_memtoreg, WB_regwrite;
  logic [4:0]  ID_rs, ID_rt;
  logic [31:0] ID_rs_data, ID_rt_data;
  logic        i_dump_start, i_dump_ready;
  logic        o_dump_valid;
  logic [4:0]  o_dump_addr;
  logic [31:0] o_dump_data;
  logic        o_dump_busy, o_dump_done;

  wb_regfile_dump #(.NBITS(32), .RBITS(5)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .WB_result(WB_result), .WB_data(WB_data), .WB_rd(WB_rd),
    .WB_memtoreg(WB_memtoreg), .WB_regwrite(WB_regwrite),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rs_data(ID_rs_data), .ID_rt_data(ID_rt_data),
    .i_dump_start(i_dump_start), .i_dump_ready(i_dump_ready),
    .o_dump_valid(o_dump_valid), .o_dump_addr(o_dump_addr), .o_dump_data(o_dump_data),
    .o_dump_busy(o_dump_busy), .o_dump_done(o_dump_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        we, m2r;
    logic [4:0]  rd;
    logic [31:0] res, dat;
    logic [4:0]  rs, rt;
    logic [31:0] ers, ert;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } dw_t;

  localparam int NV = 11;
  vec_t        vt [NV];
  dw_t         sbq [$];
  logic [31:0] mdl [32];
  int          nvec, nerr;

  function automatic vec_t mk(input int we, input int m2r, input int rd,
                              input logic [31:0] res, input logic [31:0] dat,
                              input int rs, input int rt,
                              input logic [31:0] ers, input logic [31:0] ert);
    vec_t v;
    v.we = 1'(we); v.m2r = 1'(m2r); v.rd = 5'(rd);
    v.res = res; v.dat = dat; v.rs = 5'(rs); v.rt = 5'(rt);
    v.ers = ers; v.ert = ert;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input int rd, input logic [31:0] val);
    WB_regwrite = 1'b1; WB_memtoreg = 1'b0; WB_rd = 5'(rd); WB_result = val;
    tick();
    WB_regwrite = 1'b0;
    if (rd != 0) mdl[rd] = val;
  endtask

  initial begin
    dw_t  w;
    logic hold;
    logic [4:0]  ha;
    logic [31:0] hd;
    int   dn, edges;

    nvec = 0; nerr = 0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    i_rst = 1'b0;
    WB_result = '0; WB_data = '0; WB_rd = '0; WB_memtoreg = 1'b0; WB_regwrite = 1'b0;
    ID_rs = '0; ID_rt = '0; i_dump_start = 1'b0; i_dump_ready = 1'b0;

    // Reset state
    #25;
    chk("rst_valid", 32'(o_dump_valid), 0);
    chk("rst_addr",  32'(o_dump_addr), 0);
    chk("rst_data",  o_dump_data, 0);
    chk("rst_busy",  32'(o_dump_busy), 0);
    chk("rst_done",  32'(o_dump_done), 0);
    @(negedge i_clk);
    i_rst = 1'b1;
    tick();
    for (int a = 0; a < 32; a++) begin
      ID_rs = 5'(a); ID_rt = 5'(31 - a); #1;
      chk($sformatf("rst_rs%0d", a), ID_rs_data, 0);
      chk($sformatf("rst_rt%0d", 31 - a), ID_rt_data, 0);
    end

    // Write mux, r0, bypass and disabled-write vectors
    vt[0]  = mk(0, 0,  0, 0,       0,            0, 31, 0,            0);
    vt[1]  = mk(1, 1,  7, 9,       8,            7,  1, 8,            0);
    vt[2]  = mk(1, 0,  5, 7,       3,            7,  5, 8,            7);
    vt[3]  = mk(0, 0,  0, 0,       0,            5,  7, 7,            8);
    vt[4]  = mk(1, 1,  0, 0,       32'hDEAD,     0,  0, 0,            0);
    vt[5]  = mk(0, 0,  0, 0,       0,            0,  7, 0,            8);
    vt[6]  = mk(1, 0,  3, 32'h55,  32'h99,       3,  3, 32'h55,       32'h55);
    vt[7]  = mk(0, 0,  7, 32'h1234, 32'h1234,    7,  3, 8,            32'h55);
    vt[8]  = mk(0, 0,  0, 0,       0,            7,  7, 8,            8);
    vt[9]  = mk(1, 1, 31, 0,       32'hAAAA5555, 31, 30, 32'hAAAA5555, 0);
    vt[10] = mk(0, 0,  0, 0,       0,            31, 30, 32'hAAAA5555, 0);
    for (int i = 0; i < NV; i++) begin
      WB_regwrite = vt[i].we; WB_memtoreg = vt[i].m2r; WB_rd = vt[i].rd;
      WB_result = vt[i].res; WB_data = vt[i].dat;
      ID_rs = vt[i].rs; ID_rt = vt[i].rt;
      #1;
      chk($sformatf("vec%0d_rs", i), ID_rs_data, vt[i].ers);
      chk($sformatf("vec%0d_rt", i), ID_rt_data, vt[i].ert);
      tick();
      if (vt[i].we && vt[i].rd != 0) mdl[vt[i].rd] = vt[i].m2r ? vt[i].dat : vt[i].res;
    end
    WB_regwrite = 1'b0;

    // Preload reg[n] = n*16
    for (int n = 1; n < 32; n++) wr(n, 32'(n * 16));

    // Dump 1: toggled ready, snapshot writes, next-index bypass, ignored start
    sbq.delete();
    for (int n = 0; n < 32; n++) begin
      w.a = 5'(n);
      w.d = (n == 20) ? 32'h12340020 : mdl[n];
      sbq.push_back(w);
    end
    i_dump_start = 1'b1;
    tick();
    i_dump_start = 1'b0;
    chk("d1_first_valid", 32'(o_dump_valid), 1);
    chk("d1_first_busy",  32'(o_dump_busy), 1);
    hold = 1'b0; ha = '0; hd = '0; dn = 0;
    for (int c = 0; c < 200 && sbq.size() > 0; c++) begin
      i_dump_ready = (c % 2 == 0);
      i_dump_start = (c == 5);
      WB_regwrite  = 1'b0;
      if (o_dump_valid && !i_dump_ready && o_dump_addr != 5'd0) begin
        WB_regwrite = 1'b1; WB_memtoreg = 1'b0; WB_rd = o_dump_addr;
        WB_result = 32'hFFFF_FFFF; mdl[o_dump_addr] = 32'hFFFF_FFFF;
      end else if (o_dump_valid && i_dump_ready && o_dump_addr == 5'd19) begin
        WB_regwrite = 1'b1; WB_memtoreg = 1'b1; WB_rd = 5'd20;
        WB_data = 32'h12340020; mdl[20] = 32'h12340020;
      end
      #1;
      if (hold) begin
        chk($sformatf("d1_stable_addr%0d", ha), 32'(o_dump_addr), 32'(ha));
        chk($sformatf("d1_stable_data%0d", ha), o_dump_data, hd);
      end
      if (o_dump_done) dn++;
      hold = o_dump_valid && !i_dump_ready;
      ha = o_dump_addr; hd = o_dump_data;
      if (o_dump_valid && i_dump_ready) begin
        w = sbq.pop_front();
        chk($sformatf("d1_addr%0d", w.a), 32'(o_dump_addr), 32'(w.a));
        chk($sformatf("d1_data%0d", w.a), o_dump_data, w.d);
      end
      tick();
    end
    i_dump_start = 1'b0; WB_regwrite = 1'b0; i_dump_ready = 1'b0;
    chk("d1_drain", sbq.size(), 0);
    chk("d1_no_early_done", dn, 0);
    chk("d1_done", 32'(o_dump_done), 1);
    chk("d1_done_busy", 32'(o_dump_busy), 0);
    chk("d1_done_valid", 32'(o_dump_valid), 0);
    tick();
    chk("d1_done_once", 32'(o_dump_done), 0);
    tick();
    chk("d1_idle_valid", 32'(o_dump_valid), 0);
    chk("d1_idle_busy", 32'(o_dump_busy), 0);

    // Dump 2: ready held high, latency and contents
    sbq.delete();
    for (int n = 0; n < 32; n++) begin
      w.a = 5'(n); w.d = mdl[n]; sbq.push_back(w);
    end
    i_dump_ready = 1'b1;
    i_dump_start = 1'b1;
    tick();
    i_dump_start = 1'b0;
    edges = 1;
    while (!o_dump_done && edges < 100) begin
      if (o_dump_valid && sbq.size() > 0) begin
        w = sbq.pop_front();
        chk($sformatf("d2_addr%0d", w.a), 32'(o_dump_addr), 32'(w.a));
        chk($sformatf("d2_data%0d", w.a), o_dump_data, w.d);
      end
      tick();
      edges++;
    end
    chk("d2_latency_edges", edges, 33);
    chk("d2_drain", sbq.size(), 0);
    tick();

    // Dump 3: reset asserted at addr 10
    i_dump_start = 1'b1;
    tick();
    i_dump_start = 1'b0;
    for (int c = 0; c < 100 && o_dump_addr != 5'd10; c++) tick();
    chk("d3_reach10", 32'(o_dump_addr), 10);
    #2;
    i_rst = 1'b0;
    #1;
    chk("d3_rst_valid", 32'(o_dump_valid), 0);
    chk("d3_rst_busy",  32'(o_dump_busy), 0);
    chk("d3_rst_done",  32'(o_dump_done), 0);
    chk("d3_rst_addr",  32'(o_dump_addr), 0);
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    for (int a = 0; a < 32; a++) begin
      ID_rs = 5'(a); ID_rt = 5'(31 - a); #1;
      chk($sformatf("d3_rs%0d", a), ID_rs_data, mdl[a]);
      chk($sformatf("d3_rt%0d", 31 - a), ID_rt_data, mdl[31 - a]);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (o_dump_done || o_dump_valid || o_dump_busy) dn++;
    end
    chk("d3_quiet_after_reset", dn, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/wb_regfile_dump.md
Name: wb_regfile_dump

Overview:
- Architectural register file at the consumer end of the MEM/WB pipeline register.
- Takes the WB-stage control and data outputs, performs the memtoreg select, and writes the destination register.
- Serves the two ID-stage read ports, with write-to-read bypass.
- Contains a sequential dump engine that streams all registers to the debug unit over a valid/ready handshake.

Parameters:
NBITS, 32, data width of each register and of every data port
RBITS, 5, register address width; register count is 2**RBITS

Ports:
i_clk  input  1  system clock; all state updates on rising edge
i_rst  input  1  asynchronous, active-low reset
WB_result  input  NBITS  ALU result from MEM/WB
WB_data  input  NBITS  memory load data from MEM/WB
WB_rd  input  RBITS  destination register from MEM/WB
WB_memtoreg  input  1  1 = write WB_data, 0 = write WB_result
WB_regwrite  input  1  write enable from MEM/WB
ID_rs  input  RBITS  read address A
ID_rt  input  RBITS  read address B
ID_rs_data  output  NBITS  read data A (combinational)
ID_rt_data  output  NBITS  read data B (combinational)
i_dump_start  input  1  single-cycle request to dump all registers
i_dump_ready  input  1  debug unit accepts current dump word
o_dump_valid  output  1  dump word present
o_dump_addr  output  RBITS  index of current dump word
o_dump_data  output  NBITS  value of current dump word
o_dump_busy  output  1  dump in progress
o_dump_done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (i_rst=0, asynchronous):
  - all registers = 0; FSM = IDLE.
  - o_dump_valid=0, o_dump_addr=0, o_dump_data=0, o_dump_busy=0, o_dump_done=0.
  - Reset asserted mid-dump aborts the dump with no done pulse.
- Write data: wdata = WB_memtoreg ? WB_data : WB_result.
- Write: on rising edge, if WB_regwrite=1 and WB_rd != 0, then reg[WB_rd] <= wdata.
- Register 0 is hardwired to 0; writes to it are discarded.
- Read: ID_xx_data = 0 if address = 0.
  - Else if WB_regwrite=1 and WB_rd == address, the value is wdata (same-cycle bypass).
  - Else the value is reg[address].
- Both read ports are independent; rs==rt is legal.
- Dump FSM has three states: IDLE, SEND, DONE.
  - IDLE: when i_dump_start=1, load index 0 and go to SEND. In the next cycle o_dump_valid=1, o_dump_addr=0, o_dump_data=0.
  - SEND: o_dump_busy=1. o_dump_addr and o_dump_data are registered and stay stable while valid=1 and ready=0.
  - SEND, on a valid&&ready edge with index < 2**RBITS-1: index increments, and o_dump_data loads the bypassed read of the new index (same rule as the read ports) in the same edge. o_dump_valid stays 1, so there are no bubbles.
  - SEND, on a valid&&ready edge with index = 2**RBITS-1: o_dump_valid <= 0, go to DONE.
  - DONE: o_dump_done=1 and o_dump_busy=0 for exactly one cycle, then IDLE.
- i_dump_start is ignored in SEND and DONE.
- Snapshot rule: a write to the register currently held on o_dump_data does not change the held word. The next index is sampled when it is loaded.
- Pipeline writes and ID reads are never stalled by a dump.
- Best-case dump latency: the start edge plus 2**RBITS accepted cycles plus 1 DONE cycle, i.e. 34 cycles from start to done pulse with ready held at 1.

Test Plan:
- Reset: hold i_rst=0, then release → every ID read returns 0; all dump outputs are 0; o_dump_busy=0.
- Write/mux:
  - WB_regwrite=1, WB_rd=7, WB_memtoreg=1, WB_data=8, WB_result=9 → after the edge, reading rs=7 returns 8.
  - Then WB_rd=5, WB_memtoreg=0, WB_result=7 → reading rt=5 returns 7.
- Register 0 and bypass:
  - Write WB_rd=0 with data 0xDEAD → reading rs=0 returns 0.
  - Present WB_rd=3, wdata=0x55 with ID_rs=3 in the same cycle → ID_rs_data=0x55 before the edge.
- Disabled write: WB_regwrite=0, WB_rd=7, wdata=0x1234 → reg 7 keeps 8; no bypass.
- Dump with backpressure:
  - Preload reg[n]=n*16, pulse start, toggle ready 1,0,1,… → words appear in order 0..31 with the correct data.
  - addr/data are stable during ready=0 cycles.
  - o_dump_done pulses once after addr 31 is accepted; a start pulse during the dump is ignored.
- Reset mid-dump: assert i_rst=0 at addr 10 → valid, busy and done go 0 immediately; no done pulse; all registers read 0.
